uba_dma_sequencer: RTL and testbench
====================================

# uba_dma_sequencer

Sequences one IO-device DMA transfer at a time between a Unibus device and the KS10 backplane bus. Sits directly upstream of the UBA pager: it presents the device address to the pager and consumes the translated address, page flags and page-fail. It then runs the KS10 bus cycle(s) and returns data or an NXM status to the device. It also performs the halfword merge (read-modify-write) the pager flags call for.

## Interface
- TOCNT, default 63: bus-ack timeout in clocks; only used with `UBA_DMA_TIMEOUT_EN`.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- devREQ  in  1  device transfer request; level, held until devACK or devNXM.
- devWRITE  in  1  1 = device-to-memory, 0 = memory-to-device.
- devADDR  in  36  device address, [18:35] in pager format; bit 34 = halfword select (0 = LH, 1 = RH).
- devDATAI  in  18  write data from device.
- devDATAO  out  36  read data to device, valid with devACK.
- devACK  out  1  one-clock transfer-complete pulse.
- devNXM  out  1  one-clock failure pulse.
- pageADDRO  out  36  to pager device-address input; held stable while busy.
- pageADDRI  in  36  translated address from pager.
- pageFLAGS  in  4  {RPW,E16,FTM,VLD} from pager.
- pageFAIL  in  1  pager NXM.
- busREQO  out  1  KS10 bus request; also drives the pager's request qualifier.
- busACKI  in  1  KS10 bus cycle acknowledge.
- busADDRO  out  36  KS10 bus address; [0] read flag, [3] write flag, [14:35] = pageADDRI[14:35].
- busDATAO  out  36  KS10 write data.
- busDATAI  in  36  KS10 read data.

## Operation
- States: IDLE, XLAT, RD, WR, DONE, FAIL.
- IDLE: when devREQ=1, latch devADDR, devWRITE and devDATAI; go to XLAT.
- XLAT: assert busREQO for one clock so the pager evaluates its fail condition.
  - pageFAIL=1 → FAIL.
  - Read → RD.
  - Write with FTM=1 → WR. The FTM word is {devDATAI, devDATAI}; the device presents the same 18 bits for both halves.
  - Write with FTM=0 → RD (read-modify-write).
- RD: busREQO=1 with the read flag set, until busACKI.
  - Capture busDATAI.
  - Read transfer → DONE.
  - Read-modify-write → WR, with the merged word: the latched data replaces the selected half and the other half keeps the read value.
  - If E16=1, bits [0:1] of the written half are forced to 0.
- WR: busREQO=1 with the write flag set, busDATAO = word, until busACKI → DONE.
- Read-data placement:
  - FTM=1: devDATAO = full 36-bit word.
  - FTM=0: selected half right-justified in [18:35], [0:17] = 0.
  - E16=1 additionally zeroes [18:19].
- RPW=1 on a read: after RD, perform WR of the unmodified word before DONE. This holds memory across the read-pause-write.
- DONE: pulse devACK; return to IDLE. A new request is accepted no sooner than the next clock.
- FAIL: pulse devNXM; return to IDLE.
- devREQ dropping mid-transfer is ignored; the transfer completes.
- An async reset mid-cycle drops busREQO immediately; no ack or NXM pulse is issued.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Read, no wait states (busACKI in the first RD clock): devREQ sampled at edge 0, XLAT at 1, RD at 2, devACK high in clock 3. Latency is 3 clocks.
- Read-modify-write or RPW read: 4 clocks plus bus wait states.
- FTM write: 3 clocks.
- busADDRO, busDATAO and pageADDRO are stable for the whole time busREQO is high.
- busACKI is ignored outside RD and WR.

## Configuration
- `UBA_DMA_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entry to RD or WR and increments each clock without busACKI.
  - Reaching TOCNT → FAIL; busREQO drops the same edge.
- Undefined: no counter; RD and WR wait indefinitely for busACKI.

## Test plan
- Read, FTM=0, addr bit34=1, memory word 0o123456_654321, ack after 0 wait states → devDATAO=0o000000_654321, devACK 3 clocks after request.
- Write LH, FTM=0, E16=1, devDATAI=0o777777, memory 0o111111_222222 → one read then one write of 0o177777_222222, then devACK.
- FTM write devDATAI=0o525252 → single write 0o525252_525252, no read cycle.
- pageFAIL=1 in XLAT (VLD=0) → devNXM pulse, no RD or WR bus cycle, busREQO high for exactly one clock.
- With `UBA_DMA_TIMEOUT_EN`, TOCNT=5, busACKI never asserted → devNXM 5 clocks after RD entry. Without the macro, the block remains in RD.
- Assert rst during WR → busREQO=0 asynchronously, state IDLE, no devACK; the next request completes normally.

Source files
------------

// File: rtl/uba_dma_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uba_dma_sequencer                                             |
// | Purpose  : Runs one Unibus-device DMA transfer at a time against the     |
// |            KS10 backplane bus. The device address goes to the UBA pager; |
// |            the translated address, page flags and page-fail come back.   |
// |            The block then runs the bus read and/or write and reports     |
// |            completion (devACK) or failure (devNXM) to the device. It     |
// |            also does the halfword read-modify-write the pager flags ask  |
// |            for, and the write-back of a read-pause-write read.           |
// |                                                                          |
// | Build option:                                                            |
// |   UBA_DMA_TIMEOUT_EN  adds an 8-bit bus-ack timeout counter. RD and WR   |
// |                       fail to devNXM after TOCNT clocks with no          |
// |                       busACKI. Without it RD/WR wait for ever.           |
// |                                                                          |
// | Parameters (UBA_DMA_TIMEOUT_EN only):                                    |
// |   TOCNT      bus-ack timeout in clocks, 1..255 (default 63)              |
// |                                                                          |
// | Ports (PDP-10 bit numbering, bit 0 = MSB):                               |
// |   clk        clock, all state changes on the rising edge                 |
// |   rst        asynchronous reset, active low                              |
// |   devREQ     device request, a level held until devACK/devNXM            |
// |   devWRITE   1 = device to memory, 0 = memory to device                  |
// |   devADDR    device address; bit 34 selects halfword (0 LH, 1 RH)        |
// |   devDATAI   18-bit write data from the device                           |
// |   devDATAO   read data to the device, valid with devACK                  |
// |   devACK     one-clock transfer-complete pulse                           |
// |   devNXM     one-clock failure pulse                                     |
// |   pageADDRO  device address to the pager, held while busy               |
// |   pageADDRI  translated address from the pager                           |
// |   pageFLAGS  {RPW,E16,FTM,VLD} from the pager                            |
// |   pageFAIL   pager non-existent-memory indication                        |
// |   busREQO    KS10 bus request (also the pager request qualifier)         |
// |   busACKI    KS10 bus cycle acknowledge                                  |
// |   busADDRO   KS10 address; [0] read flag, [3] write flag, [14:35] addr   |
// |   busDATAO   KS10 write data                                             |
// |   busDATAI   KS10 read data                                              |
// |                                                                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uba_dma_sequencer
`ifdef UBA_DMA_TIMEOUT_EN
  #(
    parameter int TOCNT = 63
  )
`endif
  (
    input  logic        clk,
    input  logic        rst,
    input  logic        devREQ,
    input  logic        devWRITE,
    input  logic [0:35] devADDR,
    input  logic [0:17] devDATAI,
    output logic [0:35] devDATAO,
    output logic        devACK,
    output logic        devNXM,
    output logic [0:35] pageADDRO,
    input  logic [0:35] pageADDRI,
    input  logic [0:3]  pageFLAGS,
    input  logic        pageFAIL,
    output logic        busREQO,
    input  logic        busACKI,
    output logic [0:35] busADDRO,
    output logic [0:35] busDATAO,
    input  logic [0:35] busDATAI
  );

  // Bus cycle type flags carried in the upper address bits.
  localparam logic [0:35] c_rd_flag = 36'o400000_000000;
  localparam logic [0:35] c_wr_flag = 36'o040000_000000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XLAT = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4,
    ST_FAIL = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_write;    // transfer direction latched at request
  logic        r_sel;      // halfword select latched at request (1 = RH)
  logic [0:17] r_wdata;    // device write data latched at request
  logic        r_rpw;      // pager flags latched in XLAT
  logic        r_e16;
  logic        r_ftm;
  logic [0:35] r_xaddr;    // translated address, flag bits clear

  logic [0:35] w_xaddr;
  logic [0:17] w_wr_half;
  logic [0:35] w_merged;
  logic [0:17] w_rd_half;
  logic [0:35] w_placed;
  logic        w_timeout;
  logic        w_unused;

  // Only the physical-address field of the pager output reaches the bus.
  always_comb begin
    w_xaddr         = '0;
    w_xaddr[14:35]  = pageADDRI[14:35];
  end

  // Halfword being written; an 18-bit-mode page cannot hold bits 0:1.
  always_comb begin
    w_wr_half = r_wdata;
    if (r_e16) begin
      w_wr_half[0:1] = 2'b00;
    end
  end

  // Read-modify-write word: new half from the device, other half from memory.
  always_comb begin
    if (r_sel) begin
      w_merged = {busDATAI[0:17], w_wr_half};
    end else begin
      w_merged = {w_wr_half, busDATAI[18:35]};
    end
  end

  // Read data as the device sees it: whole word for FTM, else the selected
  // half right-justified.
  always_comb begin
    w_rd_half = r_sel ? busDATAI[18:35] : busDATAI[0:17];
    if (r_ftm) begin
      w_placed = busDATAI;
    end else begin
      w_placed = {18'o000000, w_rd_half};
    end
    if (r_e16) begin
      w_placed[18:19] = 2'b00;
    end
  end

`ifdef UBA_DMA_TIMEOUT_EN
  localparam logic [7:0] c_to_last = 8'(TOCNT - 1);

  logic [7:0] r_tocnt;

  // Counts clocks spent waiting for busACKI in the current bus cycle. It is
  // zero whenever the FSM is outside RD/WR and on the clock an ack moves it
  // from RD to WR, so each bus cycle gets a fresh budget.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tocnt <= '0;
    end else if ((r_state == ST_RD || r_state == ST_WR) && !busACKI) begin
      r_tocnt <= r_tocnt + 8'd1;
    end else begin
      r_tocnt <= '0;
    end
  end

  // The edge that would take the count to TOCNT is the failing edge.
  assign w_timeout = (r_state == ST_RD || r_state == ST_WR) && !busACKI &&
                     (r_tocnt == c_to_last);
`else
  assign w_timeout = 1'b0;
`endif

  // VLD is implied by the absence of pageFAIL; the high address bits are
  // the pager's business, not the bus's.
  assign w_unused = ^{pageFLAGS[3], pageADDRI[0:13]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_write   <= 1'b0;
      r_sel     <= 1'b0;
      r_wdata   <= '0;
      r_rpw     <= 1'b0;
      r_e16     <= 1'b0;
      r_ftm     <= 1'b0;
      r_xaddr   <= '0;
      devDATAO  <= '0;
      devACK    <= 1'b0;
      devNXM    <= 1'b0;
      pageADDRO <= '0;
      busREQO   <= 1'b0;
      busADDRO  <= '0;
      busDATAO  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (devREQ) begin
            r_write   <= devWRITE;
            r_sel     <= devADDR[34];
            r_wdata   <= devDATAI;
            pageADDRO <= devADDR;
            // Request goes high for XLAT so the pager qualifies its fail.
            busREQO   <= 1'b1;
            r_state   <= ST_XLAT;
          end
        end

        ST_XLAT: begin
          r_rpw   <= pageFLAGS[0];
          r_e16   <= pageFLAGS[1];
          r_ftm   <= pageFLAGS[2];
          r_xaddr <= w_xaddr;
          if (pageFAIL) begin
            busREQO <= 1'b0;
            devNXM  <= 1'b1;
            r_state <= ST_FAIL;
          end else if (r_write && pageFLAGS[2]) begin
            // FTM write: device supplies the same 18 bits for both halves.
            busADDRO <= w_xaddr | c_wr_flag;
            busDATAO <= {r_wdata, r_wdata};
            r_state  <= ST_WR;
          end else begin
            // Plain read, or the read half of a read-modify-write.
            busADDRO <= w_xaddr | c_rd_flag;
            r_state  <= ST_RD;
          end
        end

        ST_RD: begin
          if (busACKI) begin
            if (r_write) begin
              busADDRO <= r_xaddr | c_wr_flag;
              busDATAO <= w_merged;
              r_state  <= ST_WR;
            end else begin
              devDATAO <= w_placed;
              if (r_rpw) begin
                // Read-pause-write: put the word back unchanged.
                busADDRO <= r_xaddr | c_wr_flag;
                busDATAO <= busDATAI;
                r_state  <= ST_WR;
              end else begin
                busREQO  <= 1'b0;
                busADDRO <= '0;
                devACK   <= 1'b1;
                r_state  <= ST_DONE;
              end
            end
          end else if (w_timeout) begin
            busREQO  <= 1'b0;
            busADDRO <= '0;
            devNXM   <= 1'b1;
            r_state  <= ST_FAIL;
          end
        end

        ST_WR: begin
          if (busACKI) begin
            busREQO  <= 1'b0;
            busADDRO <= '0;
            busDATAO <= '0;
            devACK   <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_timeout) begin
            busREQO  <= 1'b0;
            busADDRO <= '0;
            busDATAO <= '0;
            devNXM   <= 1'b1;
            r_state  <= ST_FAIL;
          end
        end

        ST_DONE: begin
          devACK  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_FAIL: begin
          devNXM  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          busREQO  <= 1'b0;
          busADDRO <= '0;
          busDATAO <= '0;
          devACK   <= 1'b0;
          devNXM   <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uba_dma_sequencer.sv
`default_nettype none
module tb_uba_dma_sequencer;

  typedef struct {
    logic [0:35] addr;
    logic [0:35] data;
    logic [0:35] paddr;
  } bus_t;

  typedef struct {
    bit          nxm;
    logic [0:35] data;
    int          cyc;
  } dev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        devREQ;
  logic        devWRITE;
  logic [0:35] devADDR;
  logic [0:17] devDATAI;
  logic [0:35] devDATAO;
  logic        devACK;
  logic        devNXM;
  logic [0:35] pageADDRO;
  logic [0:35] pageADDRI;
  logic [0:3]  pageFLAGS;
  logic        pageFAIL;
  logic        busREQO;
  logic        busACKI;
  logic [0:35] busADDRO;
  logic [0:35] busDATAO;
  logic [0:35] busDATAI;

  // Bench-side pager and memory models.
  logic [0:3]  pflags;
  logic        pfail;
  logic [0:35] mem_word;
  bit          ack_en;
  int          ack_wait;

  assign pageADDRI = pageADDRO + 36'o000000_001000;
  assign pageFLAGS = pflags;
  assign pageFAIL  = pfail;
  assign busDATAI  = mem_word;

  int   total;
  int   bad;
  int   cyc;
  bus_t exp_bus[$];
  bus_t obs_bus[$];
  dev_t obs_dev[$];

  // Responder / monitor state.
  int          ack_cnt;
  logic [0:35] prev_addr;
  logic        last_req;
  logic [0:35] last_addr;
  logic [0:35] last_data;
  logic [0:35] last_paddr;

  always #5 clk = ~clk;

`ifdef UBA_DMA_TIMEOUT_EN
  uba_dma_sequencer #(.TOCNT(5)) dut (
`else
  uba_dma_sequencer dut (
`endif
    .clk(clk), .rst(rst), .devREQ(devREQ), .devWRITE(devWRITE),
    .devADDR(devADDR), .devDATAI(devDATAI), .devDATAO(devDATAO),
    .devACK(devACK), .devNXM(devNXM), .pageADDRO(pageADDRO),
    .pageADDRI(pageADDRI), .pageFLAGS(pageFLAGS), .pageFAIL(pageFAIL),
    .busREQO(busREQO), .busACKI(busACKI), .busADDRO(busADDRO),
    .busDATAO(busDATAO), .busDATAI(busDATAI)
  );

  // Memory responder and output monitor, all on the falling edge.
  always @(negedge clk) begin
    bus_t b;
    dev_t d;
    cyc++;
    if (busACKI && last_req) begin
      b.addr = last_addr; b.data = last_data; b.paddr = last_paddr;
      obs_bus.push_back(b);
    end
    if (devACK || devNXM) begin
      d.nxm = devNXM; d.data = devDATAO; d.cyc = cyc;
      obs_dev.push_back(d);
    end
    if (!rst) begin
      busACKI = 1'b0; ack_cnt = 0; prev_addr = '0;
    end else if (busREQO && (busADDRO[0] || busADDRO[3])) begin
      if (busADDRO != prev_addr) ack_cnt = 0;
      prev_addr = busADDRO;
      busACKI = ack_en && (ack_cnt >= ack_wait);
      ack_cnt++;
    end else begin
      busACKI = 1'b0; prev_addr = '0;
    end
    last_req = busREQO; last_addr = busADDRO; last_data = busDATAO; last_paddr = pageADDRO;
  end

  // Expected KS10 address for device address a.
  function automatic logic [0:35] xl(input logic [0:35] a, input logic wr);
    logic [0:35] t;
    t = (a + 36'o000000_001000) & 36'o000017_777777;
    t[0] = !wr;
    t[3] = wr;
    return t;
  endfunction

  task automatic push_bus(input logic [0:35] a, input logic wr, input logic [0:35] data);
    bus_t e;
    e.addr = xl(a, wr); e.data = data; e.paddr = a;
    exp_bus.push_back(e);
  endtask

  task automatic drive_xfer(input logic wr, input logic [0:35] addr, input logic [0:17] d,
                            input logic [0:3] fl, input logic pf, input logic [0:35] mem,
                            input int budget, output bit done, output dev_t res,
                            output int lat, output int reqcyc);
    int start;
    @(negedge clk); #1;
    pflags = fl; pfail = pf; mem_word = mem;
    devADDR = addr; devWRITE = wr; devDATAI = d; devREQ = 1'b1;
    start = cyc; done = 0; reqcyc = 0; lat = 0;
    res.nxm = 0; res.data = '0; res.cyc = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (busREQO) reqcyc++;
      if (obs_dev.size() > 0) begin
        res = obs_dev.pop_front(); done = 1; lat = res.cyc - start;
      end
    end
    devREQ = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (devACK !== 1'b0 || devNXM !== 1'b0 || busREQO !== 1'b0) begin
      bad++; $display("FAIL reset_ctl: got ack=%b nxm=%b req=%b want 0 0 0", devACK, devNXM, busREQO);
    end
    total++;
    if (busADDRO !== 36'o0 || busDATAO !== 36'o0) begin
      bad++; $display("FAIL reset_bus: got addr=%o data=%o want 0 0", busADDRO, busDATAO);
    end
    total++;
    if (devDATAO !== 36'o0 || pageADDRO !== 36'o0) begin
      bad++; $display("FAIL reset_dev: got dout=%o paddr=%o want 0 0", devDATAO, pageADDRO);
    end
    rst = 1'b1;
  endtask

  task automatic test_read();
    logic [0:35] addrs [5];
    logic [0:3]  fls   [5];
    logic [0:35] mems  [5];
    logic [0:35] outs  [5];
    int          waits [5];
    bit done; dev_t r; int lat, rq; bus_t eb, ob;
    addrs = '{36'o000000_001236, 36'o000000_001234, 36'o000000_001242, 36'o000000_001250, 36'o000000_001266};
    fls   = '{4'b0001, 4'b0001, 4'b0101, 4'b0011, 4'b0001};
    mems  = '{36'o123456_654321, 36'o123456_654321, 36'o777777_777777, 36'o123456_654321, 36'o000055_000066};
    outs  = '{36'o000000_654321, 36'o000000_123456, 36'o000000_177777, 36'o123456_654321, 36'o000000_000066};
    waits = '{0, 0, 0, 0, 3};
    for (int i = 0; i < 5; i++) begin
      ack_wait = waits[i];
      push_bus(addrs[i], 1'b0, 36'o0);
      drive_xfer(1'b0, addrs[i], 18'o0, fls[i], 1'b0, mems[i], 40, done, r, lat, rq);
      total++;
      if (!done || r.nxm || r.data !== outs[i] || lat != 3 + waits[i]) begin
        bad++; $display("FAIL read%0d: got done=%0d nxm=%0d data=%o lat=%0d want 1 0 %o %0d",
                        i, done, r.nxm, r.data, lat, outs[i], 3 + waits[i]);
      end
      while (exp_bus.size() > 0) begin
        eb = exp_bus.pop_front();
        total++;
        if (obs_bus.size() == 0) begin
          bad++; $display("FAIL read%0d_bus: got none want addr=%o", i, eb.addr);
        end else begin
          ob = obs_bus.pop_front();
          if (ob.addr !== eb.addr || ob.paddr !== eb.paddr) begin
            bad++; $display("FAIL read%0d_bus: got addr=%o paddr=%o want %o %o", i, ob.addr, ob.paddr, eb.addr, eb.paddr);
          end
        end
      end
    end
    ack_wait = 0;
  endtask

  task automatic test_rmw();
    bit done; dev_t r; int lat, rq; bus_t eb, ob;
    // LH, E16, no waits
    push_bus(36'o000000_002000, 1'b0, 36'o0);
    push_bus(36'o000000_002000, 1'b1, 36'o177777_222222);
    drive_xfer(1'b1, 36'o000000_002000, 18'o777777, 4'b0101, 1'b0, 36'o111111_222222, 40, done, r, lat, rq);
    total++;
    if (!done || r.nxm || lat != 4) begin
      bad++; $display("FAIL rmw_lh: got done=%0d nxm=%0d lat=%0d want 1 0 4", done, r.nxm, lat);
    end
    // RH, no E16, two wait states per bus cycle
    ack_wait = 2;
    push_bus(36'o000000_002002, 1'b0, 36'o0);
    push_bus(36'o000000_002002, 1'b1, 36'o111111_525252);
    drive_xfer(1'b1, 36'o000000_002002, 18'o525252, 4'b0001, 1'b0, 36'o111111_222222, 40, done, r, lat, rq);
    total++;
    if (!done || r.nxm || lat != 8) begin
      bad++; $display("FAIL rmw_rh: got done=%0d nxm=%0d lat=%0d want 1 0 8", done, r.nxm, lat);
    end
    ack_wait = 0;
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front();
      total++;
      if (obs_bus.size() == 0) begin
        bad++; $display("FAIL rmw_bus: got none want addr=%o", eb.addr);
      end else begin
        ob = obs_bus.pop_front();
        if (ob.addr !== eb.addr || ob.paddr !== eb.paddr || (eb.addr[3] && ob.data !== eb.data)) begin
          bad++; $display("FAIL rmw_bus: got addr=%o data=%o want %o %o", ob.addr, ob.data, eb.addr, eb.data);
        end
      end
    end
  endtask

  task automatic test_ftm_write();
    bit done; dev_t r; int lat, rq; bus_t eb, ob;
    push_bus(36'o000000_003000, 1'b1, 36'o525252_525252);
    drive_xfer(1'b1, 36'o000000_003000, 18'o525252, 4'b0011, 1'b0, 36'o0, 40, done, r, lat, rq);
    total++;
    if (!done || r.nxm || lat != 3) begin
      bad++; $display("FAIL ftm_wr: got done=%0d nxm=%0d lat=%0d want 1 0 3", done, r.nxm, lat);
    end
    eb = exp_bus.pop_front();
    total++;
    if (obs_bus.size() != 1) begin
      bad++; $display("FAIL ftm_wr_bus: got %0d cycles want 1", obs_bus.size());
    end else begin
      ob = obs_bus.pop_front();
      if (ob.addr !== eb.addr || ob.data !== eb.data) begin
        bad++; $display("FAIL ftm_wr_bus: got addr=%o data=%o want %o %o", ob.addr, ob.data, eb.addr, eb.data);
      end
    end
    obs_bus.delete();
  endtask

  task automatic test_rpw();
    bit done; dev_t r; int lat, rq; bus_t eb, ob;
    push_bus(36'o000000_004002, 1'b0, 36'o0);
    push_bus(36'o000000_004002, 1'b1, 36'o707070_123123);
    drive_xfer(1'b0, 36'o000000_004002, 18'o0, 4'b1001, 1'b0, 36'o707070_123123, 40, done, r, lat, rq);
    total++;
    if (!done || r.nxm || r.data !== 36'o000000_123123 || lat != 4) begin
      bad++; $display("FAIL rpw: got done=%0d nxm=%0d data=%o lat=%0d want 1 0 000000123123 4", done, r.nxm, r.data, lat);
    end
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front();
      total++;
      if (obs_bus.size() == 0) begin
        bad++; $display("FAIL rpw_bus: got none want addr=%o", eb.addr);
      end else begin
        ob = obs_bus.pop_front();
        if (ob.addr !== eb.addr || (eb.addr[3] && ob.data !== eb.data)) begin
          bad++; $display("FAIL rpw_bus: got addr=%o data=%o want %o %o", ob.addr, ob.data, eb.addr, eb.data);
        end
      end
    end
  endtask

  task automatic test_fail();
    bit done; dev_t r; int lat, rq;
    drive_xfer(1'b0, 36'o000000_005000, 18'o0, 4'b0000, 1'b1, 36'o0, 40, done, r, lat, rq);
    pfail = 1'b0;
    total++;
    if (!done || !r.nxm || lat != 2) begin
      bad++; $display("FAIL pagefail: got done=%0d nxm=%0d lat=%0d want 1 1 2", done, r.nxm, lat);
    end
    total++;
    if (rq != 1 || obs_bus.size() != 0) begin
      bad++; $display("FAIL pagefail_bus: got req_clocks=%0d cycles=%0d want 1 0", rq, obs_bus.size());
    end
    obs_bus.delete();
  endtask

  task automatic test_timeout();
    bit done; dev_t r; int lat, rq;
    ack_en = 0;
`ifdef UBA_DMA_TIMEOUT_EN
    drive_xfer(1'b0, 36'o000000_006000, 18'o0, 4'b0001, 1'b0, 36'o0, 40, done, r, lat, rq);
    total++;
    if (!done || !r.nxm || lat != 7) begin
      bad++; $display("FAIL timeout: got done=%0d nxm=%0d lat=%0d want 1 1 7", done, r.nxm, lat);
    end
    total++;
    if (busREQO !== 1'b0 || obs_bus.size() != 0) begin
      bad++; $display("FAIL timeout_bus: got req=%b cycles=%0d want 0 0", busREQO, obs_bus.size());
    end
`else
    drive_xfer(1'b0, 36'o000000_006000, 18'o0, 4'b0001, 1'b0, 36'o0, 30, done, r, lat, rq);
    total++;
    if (done || busREQO !== 1'b1 || busADDRO[0] !== 1'b1) begin
      bad++; $display("FAIL hold_rd: got done=%0d req=%b rdflag=%b want 0 1 1", done, busREQO, busADDRO[0]);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    total++;
    if (busREQO !== 1'b0 || obs_dev.size() != 0) begin
      bad++; $display("FAIL hold_rd_reset: got req=%b pulses=%0d want 0 0", busREQO, obs_dev.size());
    end
`endif
    obs_bus.delete();
    obs_dev.delete();
    ack_en = 1;
  endtask

  task automatic test_reset_mid_wr();
    bit found, done; dev_t r; int lat, rq; bus_t eb, ob;
    ack_en = 0;
    @(negedge clk); #1;
    pflags = 4'b0011; pfail = 1'b0;
    devADDR = 36'o000000_007000; devWRITE = 1'b1; devDATAI = 18'o123123; devREQ = 1'b1;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk); #1;
      if (busREQO && busADDRO[3]) found = 1;
    end
    total++;
    if (!found) begin
      bad++; $display("FAIL rst_wr_reach: got no WR cycle want WR within 10 clocks");
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (busREQO !== 1'b0 || busADDRO !== 36'o0) begin
      bad++; $display("FAIL rst_wr_async: got req=%b addr=%o want 0 0", busREQO, busADDRO);
    end
    devREQ = 1'b0;
    ack_en = 1;
    @(negedge clk); #1;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (obs_dev.size() != 0 || obs_bus.size() != 0) begin
      bad++; $display("FAIL rst_wr_quiet: got pulses=%0d cycles=%0d want 0 0", obs_dev.size(), obs_bus.size());
    end
    obs_dev.delete();
    obs_bus.delete();
    push_bus(36'o000000_007000, 1'b1, 36'o123123_123123);
    drive_xfer(1'b1, 36'o000000_007000, 18'o123123, 4'b0011, 1'b0, 36'o0, 40, done, r, lat, rq);
    total++;
    if (!done || r.nxm || lat != 3) begin
      bad++; $display("FAIL rst_wr_next: got done=%0d nxm=%0d lat=%0d want 1 0 3", done, r.nxm, lat);
    end
    eb = exp_bus.pop_front();
    total++;
    if (obs_bus.size() == 0) begin
      bad++; $display("FAIL rst_wr_next_bus: got none want addr=%o", eb.addr);
    end else begin
      ob = obs_bus.pop_front();
      if (ob.addr !== eb.addr || ob.data !== eb.data) begin
        bad++; $display("FAIL rst_wr_next_bus: got addr=%o data=%o want %o %o", ob.addr, ob.data, eb.addr, eb.data);
      end
    end
    obs_bus.delete();
  endtask

  task automatic test_back_to_back();
    bit done; dev_t r; int lat, rq;
    logic [0:35] mems [2];
    logic [0:35] outs [2];
    mems = '{36'o010203_040506, 36'o665544_332211};
    outs = '{36'o000000_010203, 36'o000000_332211};
    for (int i = 0; i < 2; i++) begin
      drive_xfer(1'b0, (i == 0) ? 36'o000000_010000 : 36'o000000_010002, 18'o0, 4'b0001, 1'b0,
                 mems[i], 40, done, r, lat, rq);
      total++;
      if (!done || r.nxm || r.data !== outs[i] || lat != 3) begin
        bad++; $display("FAIL b2b%0d: got done=%0d nxm=%0d data=%o lat=%0d want 1 0 %o 3", i, done, r.nxm, r.data, lat, outs[i]);
      end
    end
    obs_bus.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want test end");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst = 1'b0; devREQ = 1'b0; devWRITE = 1'b0; devADDR = '0; devDATAI = '0;
    pflags = 4'b0001; pfail = 1'b0; mem_word = '0; ack_en = 1; ack_wait = 0;
    busACKI = 1'b0; ack_cnt = 0; prev_addr = '0;
    last_req = 1'b0; last_addr = '0; last_data = '0; last_paddr = '0;
    test_reset();
    test_read();
    test_rmw();
    test_ftm_write();
    test_rpw();
    test_fail();
    test_timeout();
    test_reset_mid_wr();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
